fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that drives the PC into the icache and consumes its registered 64-bit instruction-pair responses. It holds the fetched instructions and their PCs in a small circular queue and presents up to two of them per cycle to dual-issue decode. It also accepts redirects from the backend (branch or flush). It sits between the PC/redirect logic and decode, as the requester end of the icache `pc` / `ir_reg` / `flag_reg` / `icache_valid_reg` interface.

## Interface
- `QDEPTH`, 8: queue entries; power of two, ≥4.
- `RESET_PC`, 32'h1c000000: PC issued after reset.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `pc`  out  32  fetch address to icache.
- `icache_valid_reg`  in  1  icache response valid (registered, one cycle after `pc`).
- `ir_reg`  in  64  `[63:32]` = instruction at `pc`; `[31:0]` = instruction at `pc+4`.
- `flag_reg`  in  1  `ir_reg[31:0]` valid.
- `redirect`  in  1  flush queue and restart fetch.
- `redirect_pc`  in  32  restart address.
- `deq_num`  in  2  instructions consumed by decode this cycle (0..2).
- `inst0`, `inst1`  out  32  queue head and head+1 instruction.
- `inst0_pc`, `inst1_pc`  out  32  their PCs.
- `inst_valid`  out  2  bit0 = slot0 valid, bit1 = slot1 valid.

## Operation
- Two-state FSM: ISSUE and WAIT. Reset state is ISSUE.
- **ISSUE:** `pc` is driven with the fetch PC.
  - Go to WAIT when free entries ≥2 and there is no redirect.
  - Otherwise stay in ISSUE with `pc` held.
- **WAIT, `icache_valid_reg`=0:** stay in WAIT, `pc` held, nothing pushed.
- **WAIT, `icache_valid_reg`=1:**
  - Push `{pc, ir_reg[63:32]}`.
  - If `flag_reg`=1 and `pc[2]`=0, also push `{pc+4, ir_reg[31:0]}`. A set `flag_reg` with `pc[2]`=1 is ignored, because the pair would straddle an 8-byte boundary.
  - `pc` advances by 8 if two entries were pushed, otherwise by 4.
  - Return to ISSUE.
- **Redirect (highest priority, any state):**
  - Queue emptied (count, head and tail zeroed).
  - `pc` ← `{redirect_pc[31:2], 2'b00}`.
  - State ← ISSUE.
  - Any response and any `deq_num` in that cycle are discarded.
- **Queue:**
  - Circular; head and tail are log2(QDEPTH)-bit pointers and wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.
  - Push and dequeue in the same cycle are allowed.
  - The free-space test in ISSUE uses count before that cycle's dequeue (conservative).
  - Effective dequeue = min(`deq_num`, count). A simulation assertion flags `deq_num` > count.
- **Outputs:**
  - `inst0` / `inst0_pc` come from the head entry; `inst1` / `inst1_pc` come from head+1 (wrapping).
  - `inst_valid` = {count≥2, count≥1}.
  - All outputs are combinational from registered state only; no input-to-output paths.

## Timing
- Reset values: `pc`=RESET_PC, `inst_valid`=2'b00, `inst0`/`inst1`/`inst0_pc`/`inst1_pc`=0 (queue storage reset to zero).
- Fetch pipeline:
  - Cycle 0 after reset release: ISSUE, `pc`=RESET_PC.
  - Cycle 1: WAIT, response sampled and pushed at end of cycle.
  - Cycle 2: `inst_valid` asserted and `pc` advanced.
- Throughput: one icache response every 2 cycles (≤2 instructions).
- Redirect asserted in cycle N: `inst_valid`=00 and `pc`=target in cycle N+1; first instructions from the target appear in N+3.
- Asserting reset mid-WAIT discards the pending response; state returns to reset values on the next edge.

## Structure
- Shared package `fetch_pkg`:
  - `RESET_PC` default.
  - FSM state enum {ISSUE, WAIT}.
  - Queue entry typedef `{logic [31:0] pc; logic [31:0] inst;}`.
- Sub-module `fetch_queue`: the circular buffer with 0–2 pushes, 0–2 pops, flush, count and head/head+1 read ports.
- FSM and PC logic stay in `fetch_unit`.

## Test plan
Bench instantiates the block with RESET_PC=0, driving the icache response from a registered pc-indexed table.
- **Reset, `deq_num`=0; at pc 0 the table returns `ir_reg`={32'h02804021, 32'h28800462}, `flag_reg`=1** → cycle 2: `inst0`=02804021 @0, `inst1`=28800462 @4, `inst_valid`=11, `pc`=8.
- **Single-slot responses:** response at pc 32 with `flag_reg`=0 → one push, `pc`=36. Next response at pc 36 with `flag_reg`=1 → `pc[2]`=1, so one push only, `pc`=40.
- **Queue fill:** `deq_num` held 0, all responses `flag_reg`=1 → after 4 responses count=8 (`pc`=32), FSM parks in ISSUE with `pc` held at 32. Then `deq_num`=2 for one cycle → fetch resumes next cycle.
- **Redirect in WAIT:** redirect to 32'h103 while a valid response is present → response dropped, next cycle `inst_valid`=00 and `pc`=32'h100.
- **Push and dequeue together:** count=6 with `deq_num`=2 in the WAIT cycle of a two-instruction response → count stays 6, head advances by 2, tail wraps correctly past index 7.
- **Stalled icache:** `icache_valid_reg`=0 for 3 cycles in WAIT → `pc` stable, no pushes. On the 4th cycle valid=1 → push, FSM returns to ISSUE.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end.
//   RESET_PC_DEFAULT : default PC issued after reset
//   ENTRY_W          : width of one packed queue entry {pc, inst}
//   fetch_state_t    : fetch FSM states (ISSUE drives a new PC, WAIT takes
//                      the icache response)
//   fetch_entry_t    : one queued instruction together with its PC
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam int          ENTRY_W          = 64;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular buffer of fetched {pc, inst} entries. It takes 0..2 pushes and
// 0..2 pops per cycle and can be flushed. It exposes the head and head+1
// entries for dual-issue decode.
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   i_flush      : empty the queue (pointers and count to zero)
//   i_push_num   : number of entries pushed this cycle (0..2)
//   i_push0/1    : packed entries written at tail and tail+1
//   i_pop_num    : entries requested by decode; clipped to the current count
//   o_count      : number of valid entries
//   o_head0/1    : packed entries at head and head+1 (wrapping)
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_flush,
  input  logic [1:0]                 i_push_num,
  input  logic [ENTRY_W-1:0]         i_push0,
  input  logic [ENTRY_W-1:0]         i_push1,
  input  logic [1:0]                 i_pop_num,
  output logic [$clog2(QDEPTH):0]    o_count,
  output logic [ENTRY_W-1:0]         o_head0,
  output logic [ENTRY_W-1:0]         o_head1
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t      r_mem [QDEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [1:0]        w_popEff;
  logic [PW-1:0]     w_tailNext1;
  logic [PW-1:0]     w_headNext1;

  // Decode may ask for more than is present; only what exists is removed.
  // When the request exceeds the count the count is at most 1, so its low
  // two bits are the exact amount.
  always_comb begin
    w_popEff = i_pop_num;
    if (CW'(i_pop_num) > r_count) begin
      w_popEff = r_count[1:0];
    end
  end

  assign w_tailNext1 = r_tail + PW'(1);
  assign w_headNext1 = r_head + PW'(1);

  // Entry storage. It is cleared on reset so that the read ports show zero
  // before anything is fetched. A flush leaves the data alone because the
  // zeroed count already marks it invalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!i_flush) begin
      if (i_push_num != 2'd0) begin
        r_mem[r_tail] <= fetch_entry_t'(i_push0);
      end
      if (i_push_num == 2'd2) begin
        r_mem[w_tailNext1] <= fetch_entry_t'(i_push1);
      end
    end
  end

  // Pointers and occupancy. The pointers wrap naturally through their PW-bit
  // width. The count is one bit wider so that it can represent a full queue.
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_popEff);
      r_tail  <= r_tail + PW'(i_push_num);
      r_count <= r_count + CW'(i_push_num) - CW'(w_popEff);
    end
  end

  assign o_count = r_count;
  assign o_head0 = r_mem[r_head];
  assign o_head1 = r_mem[w_headNext1];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. It drives the fetch PC to the icache and
// queues the returned instruction pairs. It presents up to two queued
// instructions per cycle to decode. Backend redirects flush the queue and
// restart fetch.
// Ports:
//   clk, rstn         : clock, synchronous active-low reset
//   pc                : fetch address to the icache
//   icache_valid_reg  : icache response valid (one cycle after pc)
//   ir_reg            : [63:32] inst at pc, [31:0] inst at pc+4
//   flag_reg          : ir_reg[31:0] holds a valid instruction
//   redirect          : flush and restart fetch at redirect_pc
//   redirect_pc       : restart address (word aligned internally)
//   deq_num           : instructions consumed by decode this cycle (0..2)
//   inst0/inst0_pc    : queue head instruction and its PC
//   inst1/inst1_pc    : head+1 instruction and its PC
//   inst_valid        : {slot1 valid, slot0 valid}
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pc,
  input  logic        icache_valid_reg,
  input  logic [63:0] ir_reg,
  input  logic        flag_reg,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  deq_num,
  output logic [31:0] inst0,
  output logic [31:0] inst1,
  output logic [31:0] inst0_pc,
  output logic [31:0] inst1_pc,
  output logic [1:0]  inst_valid
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t      r_state;
  logic [31:0]       r_pc;

  logic              w_push;
  logic              w_two;
  logic [1:0]        w_pushNum;
  logic [1:0]        w_popNum;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_free;
  fetch_entry_t      w_push0;
  fetch_entry_t      w_push1;
  logic [ENTRY_W-1:0] w_head0;
  logic [ENTRY_W-1:0] w_head1;
  fetch_entry_t      w_head0Entry;
  fetch_entry_t      w_head1Entry;
  logic              w_unusedPcLow;

  // A response is taken only in WAIT and never in a redirect cycle. The
  // second word is used only when the pair stays inside one 8-byte block,
  // that is, when the fetch PC is 8-byte aligned.
  always_comb begin
    w_push    = (r_state == WAIT) && icache_valid_reg && !redirect;
    w_two     = flag_reg && !r_pc[2];
    w_pushNum = 2'd0;
    if (w_push) begin
      w_pushNum = w_two ? 2'd2 : 2'd1;
    end
    w_popNum  = redirect ? 2'd0 : deq_num;
  end

  assign w_push0 = '{pc: r_pc,            inst: ir_reg[63:32]};
  assign w_push1 = '{pc: r_pc + 32'd4,    inst: ir_reg[31:0]};

  // Free space is judged on the count before this cycle's dequeue. This can
  // cost a cycle, but it keeps the issue decision independent of decode.
  assign w_free = CW'(QDEPTH) - w_count;

  // Fetch FSM and PC register. A redirect overrides everything. ISSUE holds
  // the PC until two slots are free. WAIT holds until the icache answers,
  // then advances past what was actually queued.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ISSUE;
      r_pc    <= RESET_PC;
    end else if (redirect) begin
      r_state <= ISSUE;
      r_pc    <= {redirect_pc[31:2], 2'b00};
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_free >= CW'(2)) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (icache_valid_reg) begin
            r_pc    <= r_pc + (w_two ? 32'd8 : 32'd4);
            r_state <= ISSUE;
          end
        end
        default: begin
          r_state <= ISSUE;
        end
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH     (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (redirect),
    .i_push_num (w_pushNum),
    .i_push0    (w_push0),
    .i_push1    (w_push1),
    .i_pop_num  (w_popNum),
    .o_count    (w_count),
    .o_head0    (w_head0),
    .o_head1    (w_head1)
  );

  assign w_head0Entry = fetch_entry_t'(w_head0);
  assign w_head1Entry = fetch_entry_t'(w_head1);

  assign pc         = r_pc;
  assign inst0      = w_head0Entry.inst;
  assign inst0_pc   = w_head0Entry.pc;
  assign inst1      = w_head1Entry.inst;
  assign inst1_pc   = w_head1Entry.pc;
  assign inst_valid = {(w_count >= CW'(2)), (w_count >= CW'(1))};

  // The low redirect address bits are dropped by the word alignment.
  assign w_unusedPcLow = &{1'b0, redirect_pc[1:0]};

  // Decode must never consume more than is queued.
  assert property (@(posedge clk) disable iff (!rstn || redirect)
                   CW'(deq_num) <= w_count);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with RESET_PC = 0. A registered, pc-indexed
// icache model answers every request. The main process drives the directed
// vectors. Before each dequeue it pushes the hand-computed entries that decode
// is expected to receive. A monitor on the falling edge pops those entries
// and compares them with what the DUT presents whenever decode consumes.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic        icache_valid_reg;
  logic [63:0] ir_reg;
  logic        flag_reg;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_num;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic [31:0] inst0_pc;
  logic [31:0] inst1_pc;
  logic [1:0]  inst_valid;

  logic        stallResp;
  int          checks;
  int          failures;
  fetch_entry_t expQ [$];

  fetch_unit #(
    .QDEPTH           (8),
    .RESET_PC         (32'h0)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .pc               (pc),
    .icache_valid_reg (icache_valid_reg),
    .ir_reg           (ir_reg),
    .flag_reg         (flag_reg),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .deq_num          (deq_num),
    .inst0            (inst0),
    .inst1            (inst1),
    .inst0_pc         (inst0_pc),
    .inst1_pc         (inst1_pc),
    .inst_valid       (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words at 0 and 4, a tagged
  // address everywhere else.
  function automatic logic [31:0] instAt(input logic [31:0] a);
    if (a == 32'h0) return 32'h0280_4021;
    if (a == 32'h4) return 32'h2880_0462;
    return 32'hA000_0000 | a;
  endfunction

  // Registered icache. Only the pair at pc 32 has an invalid second word.
  always @(posedge clk) begin
    icache_valid_reg <= !stallResp;
    ir_reg           <= {instAt(pc), instAt(pc + 32'd4)};
    flag_reg         <= (pc != 32'd32);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic rd,
                               input logic [31:0] rpc);
    deq_num     = d;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
    deq_num     = 2'd0;
    redirect    = 1'b0;
  endtask

  task automatic expectPair(input logic [31:0] p);
    expQ.push_back('{pc: p,         inst: instAt(p)});
    expQ.push_back('{pc: p + 32'd4, inst: instAt(p + 32'd4)});
  endtask

  // Monitor: whenever decode consumes, compare the consumed slots with the
  // next expected entries.
  always @(negedge clk) begin
    if (rstn && !redirect && deq_num != 2'd0) begin
      for (int s = 0; s < 2; s++) begin
        if (s < int'(deq_num)) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL monitor_underflow: slot %0d consumed with no expected entry", s);
          end else begin
            fetch_entry_t e;
            e = expQ.pop_front();
            checkOutput(s == 0 ? "mon_inst0_pc" : "mon_inst1_pc",
                        s == 0 ? inst0_pc : inst1_pc, e.pc);
            checkOutput(s == 0 ? "mon_inst0" : "mon_inst1",
                        s == 0 ? inst0 : inst1, e.inst);
          end
        end
      end
    end
  end

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_num     = 2'd0;
    stallResp   = 1'b0;

    // Reset state.
    repeat (3) applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("rst_pc",         pc,                32'h0);
    checkOutput("rst_inst_valid", {30'd0, inst_valid}, 32'h0);
    checkOutput("rst_inst0",      inst0,             32'h0);
    checkOutput("rst_inst1",      inst1,             32'h0);
    checkOutput("rst_inst0_pc",   inst0_pc,          32'h0);
    checkOutput("rst_inst1_pc",   inst1_pc,          32'h0);

    // First fetch: cycle 0 ISSUE, cycle 1 WAIT, cycle 2 results visible.
    rstn = 1'b1;
    checkOutput("c0_pc", pc, 32'h0);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("c1_pc",    pc,                  32'h0);
    checkOutput("c1_valid", {30'd0, inst_valid}, 32'h0);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("c2_inst0",    inst0,               32'h0280_4021);
    checkOutput("c2_inst0_pc", inst0_pc,            32'h0);
    checkOutput("c2_inst1",    inst1,               32'h2880_0462);
    checkOutput("c2_inst1_pc", inst1_pc,            32'h4);
    checkOutput("c2_valid",    {30'd0, inst_valid}, 32'h3);
    checkOutput("c2_pc",       pc,                  32'h8);

    // Fill: pairs at 8, 16, 24 bring the count to 8 and fetch parks at 32.
    repeat (6) applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("fill_pc", pc, 32'd32);
    repeat (2) applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("park_pc",    pc,                  32'd32);
    checkOutput("park_valid", {30'd0, inst_valid}, 32'h3);

    // Free two slots; fetch resumes with the single-word response at 32.
    expectPair(32'd0);
    applyStimulus(2'd2, 1'b0, 32'h0);
    checkOutput("resume_issue_pc", pc, 32'd32);
    applyStimulus(2'd0, 1'b0, 32'h0);
    expectPair(32'd8);
    applyStimulus(2'd2, 1'b0, 32'h0);
    checkOutput("single32_pc",  pc,       32'd36);
    checkOutput("single32_hd",  inst0_pc, 32'd16);

    // Response at 36 has flag set but straddles an 8-byte block.
    repeat (2) applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("single36_pc", pc, 32'd40);

    // Push two and pop two at count 6; head wraps at 48, tail wraps at 56.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd0, 1'b0, 32'h0);
      expectPair(32'd16 + 32'(8 * k));
      applyStimulus(2'd2, 1'b0, 32'h0);
      checkOutput("pushpop_pc",    pc,                  32'd48 + 32'(8 * k));
      checkOutput("pushpop_valid", {30'd0, inst_valid}, 32'h3);
    end
    checkOutput("wrap_inst0_pc", inst0_pc, 32'd40);
    checkOutput("wrap_inst0",    inst0,    32'hA000_0028);
    checkOutput("wrap_inst1_pc", inst1_pc, 32'd44);

    // Stalled icache: three invalid WAIT cycles, then the response lands.
    stallResp = 1'b1;
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall1_pc", pc, 32'd64);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall2_pc", pc, 32'd64);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall3_pc", pc,       32'd64);
    checkOutput("stall3_hd", inst0_pc, 32'd40);
    stallResp = 1'b0;
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall4_pc", pc, 32'd64);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall_done_pc", pc, 32'd72);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("stall_park_pc", pc, 32'd72);

    // Redirect to 0x103 while WAIT holds a valid response; decode's request
    // in that cycle is discarded as well.
    expectPair(32'd40);
    applyStimulus(2'd2, 1'b0, 32'h0);
    applyStimulus(2'd0, 1'b0, 32'h0);
    applyStimulus(2'd2, 1'b1, 32'h103);
    checkOutput("redir_valid", {30'd0, inst_valid}, 32'h0);
    checkOutput("redir_pc",    pc,                  32'h100);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("redir_n2_valid", {30'd0, inst_valid}, 32'h0);
    applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("redir_n3_valid",    {30'd0, inst_valid}, 32'h3);
    checkOutput("redir_n3_inst0_pc", inst0_pc,            32'h100);
    checkOutput("redir_n3_inst0",    inst0,               32'hA000_0100);
    checkOutput("redir_n3_inst1_pc", inst1_pc,            32'h104);
    checkOutput("redir_n3_pc",       pc,                  32'h108);
    expectPair(32'h100);
    applyStimulus(2'd2, 1'b0, 32'h0);
    checkOutput("drain_valid", {30'd0, inst_valid}, 32'h0);
    repeat (2) applyStimulus(2'd0, 1'b0, 32'h0);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
